muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencing controller and iterative datapath for MIPS signed MULT/DIV. It accepts an operation when the ALU decoder flags a HI/LO-writing instruction (MULT or DIV), then runs a 32-step shift-add or restoring-divide loop. It owns the architectural HI/LO registers and raises a pipeline stall when a new MULT/DIV or an MFHI/MFLO read arrives while it is busy. It sits beside the ALU in the EX stage.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.
CNTW, 6, iteration counter width; must hold WIDTH.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  EX-stage instruction is MULT or DIV (hien & loen)
op_div  in  1  0 = MULT, 1 = DIV; sampled with start
srca  in  WIDTH  rs operand / dividend
srcb  in  WIDTH  rt operand / divisor
hilo_rd  in  1  EX-stage instruction is MFHI or MFLO
flush  in  1  abort the in-flight operation
busy  out  1  state != IDLE
stall  out  1  busy & (start | hilo_rd), combinational
done  out  1  one-cycle pulse; HI/LO updated this cycle
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, while reset=0): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0; internal accumulators cleared.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge N: latch |srca|, |srcb|, sign bits, op_div, and divide-by-zero flag (srcb==0).
  - Clear accumulator; count=0; go to RUN.
  - start while busy is not accepted; stall holds the instruction upstream.
- RUN: one iteration per edge, count++. After the 32nd iteration (edge N+32) go to FIX.
  - MULT: shift-add on magnitudes into a 2*WIDTH accumulator.
  - DIV: restoring divide; remainder shifted left with the next dividend bit; subtract the divisor when the remainder is >= divisor; quotient bit set accordingly.
- FIX (edge N+33): apply signs, write hi/lo, go to IDLE. done=1 in the cycle following edge N+33.
  - MULT: negate the 64-bit product if the signs differ; {hi,lo}=product.
  - DIV: lo = quotient, negated if the signs differ; hi = remainder, carrying the sign of the dividend.
  - DIV by zero: lo=32'hFFFFFFFF, hi=srca (original, signed).
  - INT_MIN / -1: lo=32'h80000000, hi=0. This falls out of the magnitude arithmetic; no special case.
- Latency: busy high in cycles after edges N..N+32 (33 cycles); hi/lo valid from edge N+33.
- hi/lo change only at FIX. They hold their old values throughout RUN, so a read that is not stalled always sees committed data.
- flush=1 in RUN or FIX: return to IDLE at the next edge; no hi/lo write, no done. flush has priority over FIX.
- flush and start in the same cycle in IDLE: flush wins; the operation is not accepted.
- start in the same cycle that FIX completes: not accepted (busy=1); accepted the following cycle.
- Reset asserted mid-operation: immediate return to the reset state; hi/lo=0.

Decomposition:
- Shared package muldiv_pkg:
  - state enum {IDLE, RUN, FIX}
  - localparams ITER=WIDTH, DIV0_LO='1
  - a sign-magnitude helper function
- One natural sub-module: muldiv_iter.
  - Combinational single-step datapath: inputs accumulator, divisor/multiplicand, op; output next accumulator.
  - The controller instantiates it and owns all registers.

Test Plan:
- MULT srca=7, srcb=-3 -> done at start+34 cycles; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high for exactly 33 cycles.
- DIV srca=-7, srcb=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIV srca=32'h80000000, srcb=-1 -> lo=32'h80000000, hi=0. DIV srca=5, srcb=0 -> lo=32'hFFFFFFFF, hi=5.
- Stall and read coherence:
  - Start MULT 0x10000 x 0x10000 with prior hi=0xAA, lo=0xBB.
  - Assert hilo_rd at cycle 10 -> stall=1 and hi=0xAA until done.
  - Second start during RUN -> stall=1, not accepted until busy=0.
  - After done: hi=1, lo=0.
- Abort: flush in RUN at count 20 -> IDLE next cycle, no done, hi/lo unchanged; a new start next cycle completes normally.
- Async reset: drop reset mid-RUN between clock edges -> busy=0, hi=lo=0 immediately, before the next edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and sign-magnitude helper for the MULT/DIV unit
package muldiv_pkg;
    localparam int DW = 32;
    localparam int ITER = DW;
    localparam logic [DW-1:0] DIV0_LO = '1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    function automatic logic [DW-1:0] smag(input logic [DW-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage handshake between the pipeline and the MULT/DIV unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic start, op_div, hilo_rd, flush, busy, stall, done;
    logic [WIDTH-1:0] srca, srcb, hi, lo;

    modport master (output start, op_div, srca, srcb, hilo_rd, flush,
                    input  busy, stall, done, hi, lo);
    modport slave  (input  start, op_div, srca, srcb, hilo_rd, flush,
                    output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: one shift-add (MULT) or restoring-divide (DIV) step on magnitudes
module muldiv_iter import muldiv_pkg::*; #(
    parameter int WIDTH = DW
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  b,
    input  logic              op_div,
    output logic [2*WIDTH:0]  nxt
);
    logic [WIDTH:0]   sum, dif;
    logic [2*WIDTH:0] sh;

    // acc holds {upper W+1 bits, lower W bits}; the extra bit absorbs the add carry
    always_comb begin
        sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b} : '0);
        sh  = {acc[2*WIDTH-1:0], 1'b0};
        dif = sh[2*WIDTH:WIDTH] - {1'b0, b};
        nxt = op_div ? ((sh[2*WIDTH:WIDTH] >= {1'b0, b}) ? {dif, sh[WIDTH-1:1], 1'b1} : sh)
                     : {1'b0, sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer, HI/LO owner and stall source for iterative signed MULT/DIV
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int WIDTH = DW,
    parameter int CNTW  = 6
) (
    input logic    clk,
    input logic    reset,
    muldiv_if.slave bus
);
    state_t            state, nstate;
    logic [CNTW-1:0]   count;
    logic [2*WIDTH:0]  acc, nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  b, hi, lo, rhi, rlo;
    logic              sa, sb, opd, dz, done, accept, wr;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (.acc(acc), .b(b), .op_div(opd), .nxt(nxt));

    always_comb begin
        accept = state == IDLE && bus.start && !bus.flush;
        wr     = state == FIX && !bus.flush;
        nstate = state == IDLE ? (accept ? RUN : IDLE)
               : state == RUN  ? (bus.flush ? IDLE : (count == CNTW'(ITER - 1) ? FIX : RUN))
               : IDLE;
        prod   = (sa ^ sb) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        // divide-by-zero leaves |srca| in the remainder, so re-signing it restores srca
        rhi    = opd ? smag(acc[2*WIDTH-1:WIDTH], sa) : prod[2*WIDTH-1:WIDTH];
        rlo    = !opd ? prod[WIDTH-1:0] : dz ? DIV0_LO : smag(acc[WIDTH-1:0], sa ^ sb);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            b     <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            opd   <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= nstate;
            done  <= wr;
            count <= accept ? '0 : (state == RUN ? count + 1'b1 : count);
            if (accept) begin
                acc <= {1'b0, {WIDTH{1'b0}}, smag(bus.srca, bus.srca[WIDTH-1])};
                b   <= smag(bus.srcb, bus.srcb[WIDTH-1]);
                sa  <= bus.srca[WIDTH-1];
                sb  <= bus.srcb[WIDTH-1];
                opd <= bus.op_div;
                dz  <= bus.srcb == '0;
            end else if (state == RUN) begin
                acc <= nxt;
            end
            if (wr) begin
                hi <= rhi;
                lo <= rlo;
            end
        end
    end

    assign bus.busy  = state != IDLE;
    assign bus.stall = bus.busy & (bus.start | bus.hilo_rd);
    assign bus.done  = done;
    assign bus.hi    = hi;
    assign bus.lo    = lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl against a signed-arithmetic model
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int fails = 0;

    muldiv_if #(.WIDTH(32)) bus();
    muldiv_ctrl #(.WIDTH(32), .CNTW(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // {hi, lo} from plain signed arithmetic
    function automatic logic [63:0] model(input logic d, input logic [31:0] a, input logic [31:0] b);
        longint x = longint'($signed(a));
        longint y = longint'($signed(b));
        if (!d) return 64'(x * y);
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {32'(x % y), 32'(x / y)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op_div = d;
        bus.srca = a;
        bus.srcb = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] want);
        int n = 0;
        chk({tag, " busy"}, bus.busy, 1);
        while (bus.busy && n < 60) begin
            n++;
            tick();
        end
        chk({tag, " cycles"}, n, 33);
        chk({tag, " done"}, bus.done, 1);
        chk({tag, " hilo"}, {bus.hi, bus.lo}, want);
        tick();
        chk({tag, " done_pulse"}, bus.done, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic d;
        int n;
        bus.start = 1'b0;
        bus.op_div = 1'b0;
        bus.srca = '0;
        bus.srcb = '0;
        bus.hilo_rd = 1'b0;
        bus.flush = 1'b0;
        #12;
        chk("rst hi", bus.hi, 0);
        chk("rst lo", bus.lo, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst stall", bus.stall, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        issue(1'b0, 32'd7, 32'hFFFFFFFD);
        wait_done("mul 7*-3", {32'hFFFFFFFF, 32'hFFFFFFEB});
        issue(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done("div -7/2", {32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div min/-1", {32'h0, 32'h80000000});
        issue(1'b1, 32'd5, 32'd0);
        wait_done("div 5/0", {32'd5, 32'hFFFFFFFF});
        issue(1'b1, 32'hFFFFFFFB, 32'd0);
        wait_done("div -5/0", {32'hFFFFFFFB, 32'hFFFFFFFF});

        issue(1'b1, 32'hBBAA, 32'h100);
        wait_done("preset", {32'hAA, 32'hBB});
        issue(1'b0, 32'h10000, 32'h10000);
        n = 0;
        while (bus.busy && n < 60) begin
            n++;
            if (n == 10) bus.hilo_rd = 1'b1;
            if (n == 15) begin
                bus.start = 1'b1;
                bus.op_div = 1'b0;
                bus.srca = 32'd3;
                bus.srcb = 32'd4;
            end
            #1;
            if (n >= 10) begin
                chk("stall", bus.stall, 1);
                chk("hold hi", bus.hi, 32'hAA);
                chk("hold lo", bus.lo, 32'hBB);
            end
            tick();
        end
        chk("stall cycles", n, 33);
        chk("stall done", bus.done, 1);
        chk("stall hilo", {bus.hi, bus.lo}, {32'h1, 32'h0});
        chk("stall released", bus.stall, 0);
        bus.hilo_rd = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_done("mul 3*4 deferred", {32'h0, 32'd12});

        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("idle flush wins", bus.busy, 0);

        issue(1'b1, 32'd100, 32'd7);
        repeat (20) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", bus.busy, 0);
        chk("flush done", bus.done, 0);
        chk("flush hilo", {bus.hi, bus.lo}, {32'h0, 32'd12});
        issue(1'b0, 32'h12345678, 32'd9);
        wait_done("after flush", {32'h0, 32'hA3D70A38});

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            d = 1'($urandom_range(0, 1));
            if (i % 4 == 1) b = 32'($urandom_range(0, 2)) - 32'd1;
            if (i % 4 == 2) a = 32'h80000000;
            issue(d, a, b);
            wait_done($sformatf("rnd%0d %s %h %h", i, d ? "div" : "mul", a, b), model(d, a, b));
        end

        issue(1'b0, 32'h10000, 32'h30000);
        wait_done("pre reset", {32'h3, 32'h0});
        issue(1'b1, 32'd1000, 32'd3);
        repeat (5) tick();
        #3;
        reset = 1'b0;
        #1;
        chk("areset busy", bus.busy, 0);
        chk("areset hi", bus.hi, 0);
        chk("areset lo", bus.lo, 0);
        chk("areset done", bus.done, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post reset idle", bus.busy, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
